// File: rtl/mem_pkg.sv
// Shared constants for the MAR-side memory responder.
// Holds the default widths, the FSM encoding and the wait-counter width.
package mem_pkg;

  localparam int AW_DEF = 6;
  localparam int DW_DEF = 8;
  localparam int CNT_W  = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/ram_array_64x8.sv
// Plain storage array for the responder.
// Writes land on the clock edge; reads are combinational.
module ram_array_64x8
  import mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder at the far end of the MAR address path.
// Latches one request, waits WAIT cycles, then completes with a ready pulse.
module mem_responder
  import mem_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int WAIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] Addr,
  input  logic [DW-1:0] Din,
  input  logic          RD,
  input  logic          WR,
  output logic [DW-1:0] Dout,
  output logic          ready,
  output logic          busy
);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    data_q, data_d;
  logic             wr_q, wr_d;
  logic [DW-1:0]    dout_q, dout_d;
  logic             ready_q, ready_d;
  logic             mem_we;
  logic [DW-1:0]    mem_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    dout_d  = dout_q;
    ready_d = 1'b0;
    mem_we  = 1'b0;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (RD | WR) begin
          addr_d  = Addr;
          data_d  = Din;
          wr_d    = WR;
          cnt_d   = CNT_W'(WAIT);
          state_d = ST_BUSY;
        end
      end
      default: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (wr_q) begin
            mem_we = 1'b1;
          end else begin
            dout_d = mem_rdata;
          end
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      dout_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
    end
  end

  // a reset landing on the commit edge must not let the write through
  ram_array_64x8 #(
    .AW(AW),
    .DW(DW)
  ) u_ram (
    .clk  (clk),
    .we   (mem_we & rst),
    .addr (addr_q),
    .wdata(data_q),
    .rdata(mem_rdata)
  );

  assign Dout  = dout_q;
  assign ready = ready_q;
  assign busy  = (state_q == ST_BUSY);

endmodule
